// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: frame width and receiver FSM state encoding.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with natural-wrap pointers; shared by the RX path and the future TX path.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             pop_acc, push_acc;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign pop_acc  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_acc);
  assign drop_o   = push_i && !push_acc;

  assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity and head_o is
  // gated to zero while empty, so no stale entry is ever visible.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, feeding a small show-ahead FIFO with sticky error flags.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_HZ = 48000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic       clk_core,
  input  logic       core_reset_n,
  input  logic       rx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);

  localparam logic [CW-1:0] FULL_BIT = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rx_s;
  rx_state_e                 state_q;
  logic [CW-1:0]             cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic                      frame_err_q, overrun_q;
  logic                      tick, stop_tick, push, drop, fifo_empty, fifo_full;

  // NOTE: sequential state always uses non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, which is what makes this a two-stage synchroniser.
  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) sync_q <= 2'b11;
    else               sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign tick      = (state_q != ST_IDLE) && (cnt_q == '0);
  assign stop_tick = (state_q == ST_STOP) && tick;
  assign push      = stop_tick && rx_s;

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (state_q != ST_IDLE && !tick) cnt_q <= cnt_q - 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt_q   <= HALF_BIT;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q     <= FULL_BIT;
              bit_idx_q <= '0;
              state_q   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg_q   <= {rx_s, shreg_q[UART_DATA_BITS-1:1]};
            cnt_q     <= FULL_BIT;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_BIT) state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop keeps half a bit of margin to catch a back-to-back start edge.
          if (tick) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (stop_tick && !rx_s) frame_err_q <= 1'b1;
      else if (err_clr)       frame_err_q <= 1'b0;

      if (drop)         overrun_q <= 1'b1;
      else if (err_clr) overrun_q <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk_core),
    .rst_n   (core_reset_n),
    .push_i  (push),
    .data_i  (shreg_q),
    .pop_i   (rd_ready),
    .head_o  (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (drop)
  );

  assign rd_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLK_HZ=16, BAUD=1 (16 clocks per bit), DEPTH=4.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int BIT_CYC   = 16;
  localparam int FRAME_CYC = 10 * BIT_CYC;

  logic       clk_core = 1'b0;
  logic       core_reset_n;
  logic       rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  int checks   = 0;
  int failures = 0;
  logic v154, v155;

  always #5 clk_core = ~clk_core;

  uart_rx_fifo #(
    .CLK_HZ(16),
    .BAUD  (1),
    .DEPTH (4)
  ) dut (
    .clk_core     (clk_core),
    .core_reset_n (core_reset_n),
    .rx           (rx),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .err_clr      (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input logic stop_ok, input int k);
    int idx;
    idx = k / BIT_CYC;
    if (idx == 0)      return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else               return stop_ok;
  endfunction

  // Start bit is driven at local cycle 0; the stop sample (and push) lands on the edge after cycle 154.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int pop_at, input int clr_at);
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk_core);
      if (k == 154) v154 = rd_valid;
      if (k == 155) v155 = rd_valid;
      rx       = frame_bit(b, stop_ok, k);
      rd_ready = (k == pop_at);
      err_clr  = (k == clr_at);
    end
    @(negedge clk_core);
    rd_ready = 1'b0;
    err_clr  = 1'b0;
    rx       = 1'b1;
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    @(negedge clk_core);
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"},  32'(rd_data),  32'(exp));
    rd_ready = 1'b1;
    @(negedge clk_core);
    rd_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_core);
  endtask

  task automatic pulse_clr();
    @(negedge clk_core);
    err_clr = 1'b1;
    @(negedge clk_core);
    err_clr = 1'b0;
  endtask

  initial begin
    rx           = 1'b1;
    rd_ready     = 1'b0;
    err_clr      = 1'b0;
    core_reset_n = 1'b0;
    idle(3);
    check("rst_valid",     32'(rd_valid),  32'd0);
    check("rst_data",      32'(rd_data),   32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    core_reset_n = 1'b1;
    idle(5);

    // 1: good frame; rd_ready held during the push cycle on an empty FIFO must not read through.
    send_byte(8'h55, 1'b1, 154, -1);
    check("t1_lat_before", 32'(v154), 32'd0);
    check("t1_lat_after",  32'(v155), 32'd1);
    check("t1_frame_err",  32'(frame_err), 32'd0);
    read_expect("t1_rd", 8'h55);
    check("t1_empty", 32'(rd_valid), 32'd0);

    // 2: short low glitch is a false start.
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    check("t2_valid",     32'(rd_valid),  32'd0);
    check("t2_frame_err", 32'(frame_err), 32'd0);
    check("t2_overrun",   32'(overrun),   32'd0);
    check("t2_idle",      32'(dut.state_q), 32'(ST_IDLE));

    // 3: bad stop bit; err_clr coinciding with the error must lose.
    send_byte(8'hA3, 1'b0, -1, 154);
    idle(30);
    check("t3_frame_err", 32'(frame_err), 32'd1);
    check("t3_valid",     32'(rd_valid),  32'd0);
    pulse_clr();
    check("t3_cleared",   32'(frame_err), 32'd0);

    // 4: five back-to-back bytes into a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, -1, -1);
    check("t4_overrun",   32'(overrun),   32'd1);
    check("t4_frame_err", 32'(frame_err), 32'd0);
    for (int i = 1; i <= 4; i++) read_expect($sformatf("t4_rd%0d", i), 8'(i));
    check("t4_empty", 32'(rd_valid), 32'd0);
    pulse_clr();
    check("t4_cleared", 32'(overrun), 32'd0);

    // 5: full FIFO, pop exactly on the fifth byte's push cycle.
    for (int i = 1; i <= 4; i++) send_byte(8'(8'h10 + i), 1'b1, -1, -1);
    send_byte(8'h15, 1'b1, 154, -1);
    check("t5_overrun", 32'(overrun), 32'd0);
    for (int i = 2; i <= 5; i++) read_expect($sformatf("t5_rd%0d", i), 8'(8'h10 + i));
    check("t5_empty", 32'(rd_valid), 32'd0);

    // 6: queued byte plus a partial frame are both lost to a reset.
    send_byte(8'h99, 1'b1, -1, -1);
    check("t6_queued", 32'(rd_valid), 32'd1);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_core);
      rx = frame_bit(8'h7E, 1'b1, k);
    end
    core_reset_n = 1'b0;
    rx = 1'b1;
    idle(2);
    check("t6_rst_valid", 32'(rd_valid), 32'd0);
    idle(3);
    core_reset_n = 1'b1;
    idle(20);
    send_byte(8'h3C, 1'b1, -1, -1);
    check("t6_frame_err", 32'(frame_err), 32'd0);
    check("t6_overrun",   32'(overrun),   32'd0);
    read_expect("t6_rd", 8'h3C);
    check("t6_empty", 32'(rd_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
